debounce_multi: RTL

Multi-channel debouncer for the board push-buttons and switches. It replaces the single-button, press-only debouncer. Each of N_CH raw inputs is synchronised, debounced symmetrically on both press and release, and presented as:
- a clean level,
- one-cycle press and release strobes,
- an optional hold/auto-repeat strobe for UI counters.

---
 rtl/debounce_multi_pkg.sv | 17 +
 rtl/debounce_multi_channel.sv | 133 +++++++++++++
 rtl/debounce_multi.sv | 50 +++++
 3 files changed

// File: rtl/debounce_multi_pkg.sv
// debounce_multi_pkg
//   Shared definitions for the multi-channel debouncer.
//   - PRESSED / RELEASED : logical button levels after polarity correction.
//   - cnt_w()            : counter width able to hold 0..v-1 (at least 1 bit).

package debounce_multi_pkg;

  localparam logic PRESSED  = 1'b1;
  localparam logic RELEASED = 1'b0;

  // Width of a counter that must reach v-1; values below 2 are treated as 2
  // so a degenerate parameter still yields a legal 1-bit counter.
  function automatic int cnt_w(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/debounce_multi_channel.sv
// debounce_channel
//   One debounced button: synchroniser, symmetric stable-time filter,
//   press/release strobes and an optional hold/auto-repeat strobe.
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_btn      raw asynchronous button input
//   o_level    debounced level, 1 = pressed
//   o_press    one-cycle strobe on accepted press
//   o_release  one-cycle strobe on accepted release
//   o_repeat   one-cycle hold/auto-repeat strobe

module debounce_channel
  import debounce_multi_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 256,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int HOLD_CYCLES   = 1024,
  parameter int REPEAT_CYCLES = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam logic RAW_IDLE = ACTIVE_LOW ? ~RELEASED : RELEASED;
  localparam int   ST_W     = cnt_w(STABLE_CYCLES);
  localparam logic [ST_W-1:0] ST_TC = ST_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [ST_W-1:0]        r_stable_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   w_sync_q;
  logic                   w_accept;
  logic                   w_press_acc;
  logic                   w_rel_acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RAW_IDLE}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end
  end

  assign w_sync_q    = r_sync[SYNC_STAGES-1] ^ logic'(ACTIVE_LOW);
  assign w_accept    = (w_sync_q != r_level) && (r_stable_cnt == ST_TC);
  assign w_press_acc = w_accept && (w_sync_q == PRESSED);
  assign w_rel_acc   = w_accept && (w_sync_q == RELEASED);

  // Counter only advances while the synchronised value disagrees with the
  // accepted level, so any reversion restarts the stable window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable_cnt <= '0;
      r_level      <= RELEASED;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
    end else begin
      r_press   <= w_press_acc;
      r_release <= w_rel_acc;
      if (w_sync_q == r_level) begin
        r_stable_cnt <= '0;
      end else if (w_accept) begin
        r_stable_cnt <= '0;
        r_level      <= w_sync_q;
      end else begin
        r_stable_cnt <= r_stable_cnt + 1'b1;
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

  if (HOLD_CYCLES > 0) begin : g_hold
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = cnt_w(HMAX);
    localparam logic [HW-1:0] HOLD_TC = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_TC  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam bit            REP_EN  = (REPEAT_CYCLES > 0);

    logic [HW-1:0] r_hold_cnt;
    logic          r_rep_phase;   // 0: waiting for first hold strobe, 1: repeating
    logic          r_repeat;

    // The counter restarts after every strobe and never passes its terminal
    // value; with repeat disabled it parks in phase 1, so long holds stay quiet.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_hold_cnt  <= '0;
        r_rep_phase <= 1'b0;
        r_repeat    <= 1'b0;
      end else begin
        r_repeat <= 1'b0;
        if (w_press_acc || w_rel_acc) begin
          r_hold_cnt  <= '0;
          r_rep_phase <= 1'b0;
        end else if (r_level == PRESSED) begin
          if (!r_rep_phase) begin
            if (r_hold_cnt == HOLD_TC) begin
              r_repeat    <= 1'b1;
              r_hold_cnt  <= '0;
              r_rep_phase <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end else if (REP_EN) begin
            if (r_hold_cnt == REP_TC) begin
              r_repeat   <= 1'b1;
              r_hold_cnt <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
        end
      end
    end

    assign o_repeat = r_repeat;
  end else begin : g_no_hold
    assign o_repeat = 1'b0;
  end

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi
//   N_CH independent button debouncers with level, press/release strobes and
//   hold/auto-repeat strobe per channel.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   btn_in       raw asynchronous button inputs
//   btn_level    debounced levels, 1 = pressed
//   btn_press    one-cycle press strobes
//   btn_release  one-cycle release strobes
//   btn_repeat   one-cycle hold/auto-repeat strobes

module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 256,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int HOLD_CYCLES   = 1024,
  parameter int REPEAT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_repeat
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_btn    (btn_in[gi]),
      .o_level  (btn_level[gi]),
      .o_press  (btn_press[gi]),
      .o_release(btn_release[gi]),
      .o_repeat (btn_repeat[gi])
    );
  end

endmodule
